// File: rtl/dn_route_ctrl_if.sv
// Configuration handshake and router-control bundle for dn_route_ctrl.
// The slave modport is the sequencer; the master modport is the configuration source.
interface dn_route_ctrl_if #(
  parameter int NUM_ROUTERS = 8,
  parameter int CNT_W       = 8
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [2*NUM_ROUTERS-1:0] cfg_route;
  logic [CNT_W-1:0]         cfg_len;
  logic                     set_en;
  logic                     route_en;
  logic [2*NUM_ROUTERS-1:0] route_signal;
  logic                     busy;
  logic                     done;
  logic [15:0]              stat_cnt;

  modport master (
    output cfg_valid, cfg_route, cfg_len,
    input  cfg_ready, set_en, route_en, route_signal, busy, done, stat_cnt
  );

  modport slave (
    input  cfg_valid, cfg_route, cfg_len,
    output cfg_ready, set_en, route_en, route_signal, busy, done, stat_cnt
  );
endinterface

// File: rtl/dn_route_ctrl.sv
// Route sequencer for a bank of dn_router instances: one-entry shadow, ROUTE for len cycles, DRAIN.
// Optional completed-configuration counter enabled by defining DN_ROUTE_CTRL_STATS_EN.
module dn_route_ctrl #(
  parameter int NUM_ROUTERS = 8,
  parameter int NUM_LEVELS  = 3,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  dn_route_ctrl_if.slave bus
);
  localparam int RW = 2 * NUM_ROUTERS;
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(NUM_LEVELS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            shadow_full_q, shadow_full_d;
  logic [RW-1:0]   shadow_route_q, shadow_route_d;
  logic [CNT_W-1:0] shadow_len_q, shadow_len_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            set_en_q, set_en_d;
  logic            route_en_q, route_en_d;
  logic [RW-1:0]   route_signal_q, route_signal_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xfer;
  logic            load;

  // cfg_ready_q always mirrors ~shadow_full_q, so it alone qualifies a transfer
  assign xfer = bus.cfg_valid && cfg_ready_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    route_signal_d = route_signal_q;
    load           = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (shadow_full_q) begin
          load = 1'b1;
        end
      end
      ROUTE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LEN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_ONE) begin
          done_d = 1'b1;
          if (shadow_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A zero-length configuration skips ROUTE but still presents its route while draining
    if (load) begin
      route_signal_d = shadow_route_q;
      if (shadow_len_q == '0) begin
        state_d = DRAIN;
        cnt_d   = DRAIN_LEN;
      end else begin
        state_d = ROUTE;
        cnt_d   = shadow_len_q;
      end
    end

    set_en_d   = (state_d == ROUTE);
    route_en_d = (state_d == ROUTE);
    busy_d     = (state_d != IDLE);
  end

  always_comb begin
    shadow_route_d = shadow_route_q;
    shadow_len_d   = shadow_len_q;
    shadow_full_d  = xfer | (shadow_full_q & ~load);
    if (xfer) begin
      shadow_route_d = bus.cfg_route;
      shadow_len_d   = bus.cfg_len;
    end
    cfg_ready_d = ~shadow_full_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shadow_full_q  <= 1'b0;
      shadow_route_q <= '0;
      shadow_len_q   <= '0;
      cfg_ready_q    <= 1'b1;
      set_en_q       <= 1'b0;
      route_en_q     <= 1'b0;
      route_signal_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_full_q  <= shadow_full_d;
      shadow_route_q <= shadow_route_d;
      shadow_len_q   <= shadow_len_d;
      cfg_ready_q    <= cfg_ready_d;
      set_en_q       <= set_en_d;
      route_en_q     <= route_en_d;
      route_signal_q <= route_signal_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.set_en    = set_en_q;
  assign bus.route_en  = route_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Each router owns a 2-bit slice of the active route
  for (genvar gi = 0; gi < NUM_ROUTERS; gi++) begin : g_router
    assign bus.route_signal[2*gi +: 2] = route_signal_q[2*gi +: 2];
  end

`ifdef DN_ROUTE_CTRL_STATS_EN
  logic [15:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (done_d) begin
      stat_cnt_d = stat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_cnt_q <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign bus.stat_cnt = stat_cnt_q;
`else
  assign bus.stat_cnt = 16'h0000;
`endif

endmodule
